mux_scan_ctrl: RTL and testbench

- Sequencer that walks a 16-to-1 mux: drives its `select`, samples its single-bit `outd`, and reassembles the bits into a parallel word.
- Sits around mux_16to1: upstream of it, driving `select`, and downstream of it, consuming `outd`.
- Delivers the captured word on a valid/ready output port.
- Supports single-shot and continuous scanning, plus abort.

---
 rtl/mux_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scans a WIDTH-to-1 mux by stepping its select, samples the mux output and
// delivers the reassembled word on a valid/ready port; single-shot or continuous.
module mux_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int SEL_W = $clog2(WIDTH),
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  output logic [SEL_W-1:0] select,
  input  logic             outd,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  // state  | meaning
  // S_IDLE | waiting for start; select parked at 0
  // S_SCAN | stepping select, sampling outd on the last dwell cycle
  // S_HOLD | full word on dout, waiting for the consumer handshake
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cont;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_busy;

  logic             w_last_dwell;
  logic             w_last_sel;
  logic [WIDTH-1:0] w_word;

  assign w_last_dwell = (r_cnt == CNT_W'(DWELL - 1));
  assign w_last_sel   = (r_sel == SEL_W'(WIDTH - 1));

  // The final capture goes straight to dout, so merge the live bit here.
  always_comb begin
    w_word        = r_asm;
    w_word[r_sel] = outd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_cont  <= 1'b0;
      r_asm   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_SCAN;
            r_cont  <= cont;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_busy  <= 1'b0;
          end else if (w_last_dwell) begin
            r_asm[r_sel] <= outd;
            r_cnt        <= '0;
            if (w_last_sel) begin
              r_dout  <= w_word;
              r_valid <= 1'b1;
              r_sel   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_sel <= r_sel + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (dout_ready) begin
            r_valid <= 1'b0;
            if (r_cont && !abort) begin
              r_state <= S_SCAN;
              r_sel   <= '0;
              r_cnt   <= '0;
              r_asm   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (abort) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= '0;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign select     = r_sel;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one DWELL=1 and one DWELL=3 instance, each driving
// a behavioural 16-to-1 mux; expected words go through a scoreboard queue.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, cont_a, abort_a, ready_a, outd_a, valid_a, busy_a;
  logic [3:0]  select_a;
  logic [15:0] datain_a, dout_a;
  logic        rst_b, start_b, cont_b, abort_b, ready_b, outd_b, valid_b, busy_b;
  logic [3:0]  select_b;
  logic [15:0] datain_b, dout_b;

  assign outd_a = datain_a[select_a];
  assign outd_b = datain_b[select_b];

  mux_scan_ctrl #(.WIDTH(16), .DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst_a), .start(start_a), .cont(cont_a), .abort(abort_a),
    .select(select_a), .outd(outd_a), .dout(dout_a), .dout_valid(valid_a),
    .dout_ready(ready_a), .busy(busy_a));

  mux_scan_ctrl #(.WIDTH(16), .DWELL(3)) u_dut3 (
    .clk(clk), .rst(rst_b), .start(start_b), .cont(cont_b), .abort(abort_b),
    .select(select_b), .outd(outd_b), .dout(dout_b), .dout_valid(valid_b),
    .dout_ready(ready_b), .busy(busy_b));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Follows a DWELL=1 scan that has just entered SCAN at select=0 through to
  // dout_valid, then pops the expected word and compares.
  task automatic wait_word_a(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (k < 16) begin
        if (select_a !== 4'(k) || valid_a !== 1'b0) begin
          n_err++;
          $display("FAIL %s_step%0d: select=%0d valid=%b, expected select=%0d valid=0",
                   tag, k, select_a, valid_a, k);
        end
      end else if (valid_a !== 1'b1 || select_a !== 4'd0) begin
        n_err++;
        $display("FAIL %s_valid: valid=%b select=%0d, expected valid=1 select=0",
                 tag, valid_a, select_a);
      end
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_word: got %h with empty scoreboard", tag, dout_a);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout_a !== exp_w) begin
        n_err++;
        $display("FAIL %s_word: dout=%h expected %h", tag, dout_a, exp_w);
      end
    end
  endtask

  task automatic start_a_scan(input logic [15:0] word, input logic c, input logic push,
                              input string tag);
    datain_a = word;
    cont_a   = c;
    start_a  = 1'b1;
    if (push) exp_q.push_back(word);
    tick();
    start_a = 1'b0;
    cont_a  = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1 || select_a !== 4'd0 || valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL %s_enter: busy=%b select=%0d valid=%b, expected 1/0/0",
               tag, busy_a, select_a, valid_a);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; start_a = 1'b1; rst_b = 1'b1; start_b = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (select_a !== 4'd0 || dout_a !== 16'h0 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a: select=%0d dout=%h valid=%b busy=%b, expected all 0",
               select_a, dout_a, valid_a, busy_a);
    end
    n_cmp++;
    if (select_b !== 4'd0 || dout_b !== 16'h0 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b: select=%0d dout=%h valid=%b busy=%b, expected all 0",
               select_b, dout_b, valid_b, busy_b);
    end
    rst_a = 1'b0; start_a = 1'b0; rst_b = 1'b0; start_b = 1'b0;
    tick();
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_scan: busy_a=%b busy_b=%b, expected 0", busy_a, busy_b);
    end
  endtask

  task automatic test_single();
    start_a_scan(16'hA5C3, 1'b0, 1'b1, "single");
    wait_word_a("single");
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    n_cmp++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || dout_a !== 16'hA5C3) begin
      n_err++;
      $display("FAIL single_done: valid=%b busy=%b dout=%h, expected 0/0/a5c3",
               valid_a, busy_a, dout_a);
    end
  endtask

  task automatic test_backpressure();
    start_a_scan(16'h0001, 1'b0, 1'b1, "bp");
    wait_word_a("bp");
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (valid_a !== 1'b1 || dout_a !== 16'h0001 || busy_a !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b dout=%h busy=%b, expected 1/0001/1",
                 k, valid_a, dout_a, busy_a);
      end
    end
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    n_cmp++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: valid=%b busy=%b, expected 0/0", valid_a, busy_a);
    end
  endtask

  task automatic test_continuous();
    ready_a = 1'b1;
    start_a_scan(16'hFFFF, 1'b1, 1'b1, "cont1");
    wait_word_a("cont1");
    datain_a = 16'h8000;
    exp_q.push_back(16'h8000);
    tick();
    n_cmp++;
    if (busy_a !== 1'b1 || select_a !== 4'd0 || valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL cont_restart: busy=%b select=%0d valid=%b, expected 1/0/0",
               busy_a, select_a, valid_a);
    end
    wait_word_a("cont2");
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    ready_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0 || select_a !== 4'd0) begin
      n_err++;
      $display("FAIL cont_abort: busy=%b valid=%b select=%0d, expected 0/0/0",
               busy_a, valid_a, select_a);
    end
    tick();
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL cont_stays_idle: busy=%b, expected 0", busy_a);
    end
  endtask

  task automatic test_abort();
    int seen_valid;
    start_a_scan(16'h1234, 1'b0, 1'b0, "abort");
    for (int k = 0; k < 7; k++) tick();
    n_cmp++;
    if (select_a !== 4'd7) begin
      n_err++;
      $display("FAIL abort_pos: select=%0d, expected 7", select_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b0 || select_a !== 4'd0 || valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b select=%0d valid=%b, expected 0/0/0",
               busy_a, select_a, valid_a);
    end
    seen_valid = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid_a !== 1'b0) seen_valid++;
    end
    n_cmp++;
    if (seen_valid != 0) begin
      n_err++;
      $display("FAIL abort_no_valid: valid seen %0d cycles, expected 0", seen_valid);
    end
    start_a_scan(16'h3C96, 1'b0, 1'b1, "after_abort");
    wait_word_a("after_abort");
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
  endtask

  task automatic test_dwell3();
    datain_b = 16'h5555;
    start_b  = 1'b1;
    exp_q.push_back(16'h5555);
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      n_cmp++;
      if (k < 48) begin
        if (select_b !== 4'(k / 3) || valid_b !== 1'b0) begin
          n_err++;
          $display("FAIL dwell3_step%0d: select=%0d valid=%b, expected select=%0d valid=0",
                   k, select_b, valid_b, k / 3);
        end
      end else if (valid_b !== 1'b1 || select_b !== 4'd0) begin
        n_err++;
        $display("FAIL dwell3_valid: valid=%b select=%0d, expected 1/0", valid_b, select_b);
      end
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL dwell3_word: got %h with empty scoreboard", dout_b);
    end else begin
      exp_w = exp_q.pop_front();
      if (dout_b !== exp_w) begin
        n_err++;
        $display("FAIL dwell3_word: dout=%h expected %h", dout_b, exp_w);
      end
    end
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 28; k++) tick();
    n_cmp++;
    if (select_b !== 4'd9 || busy_b !== 1'b1 || dout_b !== 16'h5555) begin
      n_err++;
      $display("FAIL dwell3_rerun: select=%0d busy=%b dout=%h, expected 9/1/5555",
               select_b, busy_b, dout_b);
    end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    n_cmp++;
    if (select_b !== 4'd0 || dout_b !== 16'h0 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL dwell3_rst: select=%0d dout=%h valid=%b busy=%b, expected all 0",
               select_b, dout_b, valid_b, busy_b);
    end
  endtask

  initial begin
    cont_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0; datain_a = '0;
    cont_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0; datain_b = '0;
    rst_a = 1'b1; start_a = 1'b0; rst_b = 1'b1; start_b = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_continuous();
    test_abort();
    test_dwell3();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d words never delivered, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
